lcd_ctrl: RTL

HD44780-compatible character-LCD driver. It consumes the 32-bit LCD control word held by the load/store unit's LCD register at 0x1000_4000 and turns each new software command into a correctly timed bus transaction on the LCD pins. Software issues a command by writing a new word with bit 30 inverted, and polls `o_busy` through a spare switch-input bit. The block also enforces the power-on delay before the first command.

---
 rtl/lcd_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// Purpose : HD44780-style character LCD driver; turns toggle-flagged control words into timed EN strobes.
// Latency : accept 1 cycle after the toggle is registered; busy for SETUP+EN+HOLD+WAIT cycles per command.
// Backpr. : no handshake; o_busy is polled by software, and only the net parity of toggles seen while busy counts.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_lcd_word[31:0]        [31] ON, [30] request toggle, [9] RS, [7:0] DATA; other bits unused
//   o_lcd_data, o_lcd_rs    LCD bus, latched on command accept and stable until the next accept
//   o_lcd_rw                always 0 (write-only)
//   o_lcd_en                enable strobe
//   o_lcd_on                registered copy of i_lcd_word[31]
//   o_busy                  high during power-on wait and while a command is in flight
module lcd_ctrl #(
   parameter int INIT_CYC  = 750000,
   parameter int SETUP_CYC = 2,
   parameter int EN_CYC    = 12,
   parameter int HOLD_CYC  = 2,
   parameter int EXEC_CYC  = 2000,
   parameter int SLOW_CYC  = 82000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_lcd_word,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on,
   output logic        o_busy
);

   localparam int MAX_A   = (INIT_CYC > SETUP_CYC) ? INIT_CYC : SETUP_CYC;
   localparam int MAX_B   = (EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC;
   localparam int MAX_C   = (EXEC_CYC > SLOW_CYC) ? EXEC_CYC : SLOW_CYC;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_WAIT  = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          cnt_done;

   // Input word is registered once; the toggle compare and the accepted
   // RS/DATA all come from this copy so they belong to the same cycle.
   logic          tog_in_q;
   logic          rs_in_q;
   logic [7:0]    data_in_q;

   logic          tog_q;
   logic          slow_q;
   logic          accept;
   logic          busy_nxt;
   logic          en_nxt;

   logic          unused_bits;
   assign unused_bits = ^{i_lcd_word[29:10], i_lcd_word[8]};

   assign cnt_done = (cnt == '0);
   assign accept   = (state == ST_IDLE) && (tog_in_q != tog_q);
   assign o_lcd_rw = 1'b0;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_INIT;
         cnt   <= CW'(INIT_CYC - 1);
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state / counter reload. Each timed state loads cnt with its
   // length minus one on entry and leaves on the cycle cnt reads zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_INIT: begin
            if (cnt_done) state_nxt = ST_IDLE;
            else          cnt_nxt   = cnt - CW'(1);
         end
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SETUP;
               cnt_nxt   = CW'(SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (cnt_done) begin
               state_nxt = ST_PULSE;
               cnt_nxt   = CW'(EN_CYC - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_done) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CW'(HOLD_CYC - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_done) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = slow_q ? CW'(SLOW_CYC - 1) : CW'(EXEC_CYC - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_WAIT: begin
            if (cnt_done) state_nxt = ST_IDLE;
            else          cnt_nxt   = cnt - CW'(1);
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = CW'(INIT_CYC - 1);
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs line up
   // with the state they describe.
   always_comb begin
      busy_nxt = (state_nxt != ST_IDLE);
      en_nxt   = (state_nxt == ST_PULSE);
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // Resampling the toggle during reset absorbs any request that was
         // pending (or aborted) so it never fires after the power-on wait.
         tog_in_q   <= i_lcd_word[30];
         rs_in_q    <= i_lcd_word[9];
         data_in_q  <= i_lcd_word[7:0];
         tog_q      <= i_lcd_word[30];
         slow_q     <= 1'b0;
         o_lcd_data <= 8'h00;
         o_lcd_rs   <= 1'b0;
         o_lcd_on   <= 1'b0;
         o_busy     <= 1'b1;
         o_lcd_en   <= 1'b0;
      end else begin
         tog_in_q  <= i_lcd_word[30];
         rs_in_q   <= i_lcd_word[9];
         data_in_q <= i_lcd_word[7:0];
         o_lcd_on  <= i_lcd_word[31];
         o_busy    <= busy_nxt;
         o_lcd_en  <= en_nxt;
         if (accept) begin
            tog_q      <= tog_in_q;
            o_lcd_data <= data_in_q;
            o_lcd_rs   <= rs_in_q;
            // Clear display / return home need the long execution wait.
            slow_q     <= !rs_in_q && ((data_in_q == 8'h01) ||
                                       (data_in_q == 8'h02) ||
                                       (data_in_q == 8'h03));
         end
      end
   end

endmodule
